// File: rtl/servo_seq_pkg.sv
// Shared types and helpers for the servo pose sequencer.
package servo_seq_pkg;

    localparam int ANGLE_W = 8;
    localparam int HOLD_W  = 8;

    // One queued pose: four servo angles in degrees plus dwell in frames.
    typedef struct packed {
        logic [ANGLE_W-1:0] a1;
        logic [ANGLE_W-1:0] a2;
        logic [ANGLE_W-1:0] a3;
        logic [ANGLE_W-1:0] a4;
        logic [HOLD_W-1:0]  hold;
    } pose_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    // Clock cycles in one PWM frame.
    function automatic int frame_cycles(input int clk_hz, input int frame_us);
        return (clk_hz / 1000000) * frame_us;
    endfunction

endpackage

// File: rtl/pose_fifo.sv
// Small synchronous FIFO of pose_t with first-word fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module pose_fifo
    import servo_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  pose_t                  wdata,
    output pose_t                  rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    pose_t           mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/servo_pose_sequencer.sv
// Servo pose sequencer: queues 4-servo pose commands and applies them to the
// PWM servo controller only on 20 ms frame boundaries, holding each for its
// commanded number of frames.
// Optional: define SERVO_SLEW_LIMIT_EN to make outputs ramp toward each pose
// by at most STEP degrees per frame instead of jumping.
module servo_pose_sequencer
    import servo_seq_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int FRAME_US    = 20000,
    parameter int DEPTH       = 4,
    parameter int MAX_ANGLE   = 180,
    parameter int RESET_ANGLE = 90,
    parameter int STEP        = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ANGLE_W-1:0]     cmd_angle1,
    input  logic [ANGLE_W-1:0]     cmd_angle2,
    input  logic [ANGLE_W-1:0]     cmd_angle3,
    input  logic [ANGLE_W-1:0]     cmd_angle4,
    input  logic [HOLD_W-1:0]      cmd_hold,
    input  logic                   enable,
    output logic [ANGLE_W-1:0]     angle1,
    output logic [ANGLE_W-1:0]     angle2,
    output logic [ANGLE_W-1:0]     angle3,
    output logic [ANGLE_W-1:0]     angle4,
    output logic                   nextangle,
    output logic                   frame_tick,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   err_range
);

    localparam int                 FRAME_CYCLES = frame_cycles(CLK_HZ, FRAME_US);
    localparam int                 CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [ANGLE_W-1:0] MAX_A        = ANGLE_W'(MAX_ANGLE);
    localparam logic [ANGLE_W-1:0] RST_A        = ANGLE_W'(RESET_ANGLE);

    // Saturate a commanded angle to the mechanical limit.
    function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
        return (a > MAX_A) ? MAX_A : a;
    endfunction

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic [ANGLE_W-1:0] STEP_A = ANGLE_W'(STEP);

    // Move cur toward tgt by at most STEP degrees.
    function automatic logic [ANGLE_W-1:0] step_toward(input logic [ANGLE_W-1:0] cur,
                                                       input logic [ANGLE_W-1:0] tgt);
        logic signed [ANGLE_W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > $signed({1'b0, STEP_A}))
            return cur + STEP_A;
        else if (diff < -$signed({1'b0, STEP_A}))
            return cur - STEP_A;
        else
            return tgt;
    endfunction
`else
    logic [ANGLE_W-1:0] step_unused;
    assign step_unused = ANGLE_W'(STEP);
`endif

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ANGLE_W-1:0]  ang_q [4];
    logic [ANGLE_W-1:0]  ang_d [4];
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                nextangle_q, nextangle_d;
    logic                err_q, err_d;
    logic                tick;
    logic                push, pop, count_frame;
    logic                fifo_full, fifo_empty;
    logic                any_clamped;
    pose_t               wr_pose, rd_pose;

`ifdef SERVO_SLEW_LIMIT_EN
    logic [ANGLE_W-1:0]  tgt_q [4];
    logic [ANGLE_W-1:0]  tgt_d [4];
    logic                settled;
    assign settled = (ang_q[0] == tgt_q[0]) && (ang_q[1] == tgt_q[1]) &&
                     (ang_q[2] == tgt_q[2]) && (ang_q[3] == tgt_q[3]);
`endif

    assign tick        = (cnt_q == CNT_LAST);
    assign cmd_ready   = !fifo_full;
    assign push        = cmd_valid && cmd_ready;
    assign any_clamped = (cmd_angle1 > MAX_A) || (cmd_angle2 > MAX_A) ||
                         (cmd_angle3 > MAX_A) || (cmd_angle4 > MAX_A);
    assign wr_pose     = '{a1: clamp_angle(cmd_angle1), a2: clamp_angle(cmd_angle2),
                           a3: clamp_angle(cmd_angle3), a4: clamp_angle(cmd_angle4),
                           hold: cmd_hold};
    assign err_d       = push && any_clamped;

    pose_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_pose),
        .rdata (rd_pose),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Free-running frame timer, wraps every FRAME_CYCLES.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Sequencer next-state: frame-aligned pops, dwell countdown, pose output.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        ang_d       = ang_q;
        nextangle_d = 1'b0;
        pop         = 1'b0;
        count_frame = 1'b0;
`ifdef SERVO_SLEW_LIMIT_EN
        tgt_d       = tgt_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick && enable && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (tick) begin
`ifdef SERVO_SLEW_LIMIT_EN
                    // Dwell time only starts once every output has arrived.
                    if (!settled) begin
                        for (int i = 0; i < 4; i++) ang_d[i] = step_toward(ang_q[i], tgt_q[i]);
                        nextangle_d = 1'b1;
                    end else begin
                        count_frame = 1'b1;
                    end
`else
                    count_frame = 1'b1;
`endif
                end
                if (count_frame) begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q == HOLD_W'(1)) begin
                        if (enable && !fifo_empty) begin
                            pop     = 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            // A dwell of zero frames is treated as one.
            hold_d = (rd_pose.hold == '0) ? HOLD_W'(1) : rd_pose.hold;
`ifdef SERVO_SLEW_LIMIT_EN
            tgt_d[0] = rd_pose.a1;
            tgt_d[1] = rd_pose.a2;
            tgt_d[2] = rd_pose.a3;
            tgt_d[3] = rd_pose.a4;
`else
            ang_d[0]    = rd_pose.a1;
            ang_d[1]    = rd_pose.a2;
            ang_d[2]    = rd_pose.a3;
            ang_d[3]    = rd_pose.a4;
            nextangle_d = 1'b1;
`endif
        end
    end

    // State, timer and output registers; reset restores the rest pose silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            nextangle_q <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) ang_q[i] <= RST_A;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            nextangle_q <= nextangle_d;
            err_q       <= err_d;
            ang_q       <= ang_d;
        end
    end

`ifdef SERVO_SLEW_LIMIT_EN
    // Slew targets; start equal to the rest pose so nothing moves after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) tgt_q[i] <= RST_A;
        end else begin
            tgt_q <= tgt_d;
        end
    end
`endif

    assign angle1     = ang_q[0];
    assign angle2     = ang_q[1];
    assign angle3     = ang_q[2];
    assign angle4     = ang_q[3];
    assign nextangle  = nextangle_q;
    assign frame_tick = tick;
    assign busy       = (state_q == LOAD) || (state_q == HOLD);
    assign err_range  = err_q;

endmodule

// File: tb/tb_servo_pose_sequencer.sv
// Self-checking bench for servo_pose_sequencer (20 us frames at 50 MHz).
module tb_servo_pose_sequencer;

    localparam int FC    = 1000;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_angle1 = '0, cmd_angle2 = '0, cmd_angle3 = '0, cmd_angle4 = '0;
    logic [7:0] cmd_hold = '0;
    logic       enable = 1'b1;
    logic [7:0] angle1, angle2, angle3, angle4;
    logic       nextangle, frame_tick, busy, err_range;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    // Frame-level reference model.
    logic [39:0] mq [$];
    logic [7:0]  m_ang [4];
    bit          m_busy;
    bit          m_pulse;
    int          m_rem;

    always #5 clk = ~clk;

    servo_pose_sequencer #(
        .CLK_HZ(50000000), .FRAME_US(20), .DEPTH(DEPTH),
        .MAX_ANGLE(180), .RESET_ANGLE(90), .STEP(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_angle1(cmd_angle1), .cmd_angle2(cmd_angle2), .cmd_angle3(cmd_angle3),
        .cmd_angle4(cmd_angle4), .cmd_hold(cmd_hold), .enable(enable),
        .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
        .nextangle(nextangle), .frame_tick(frame_tick), .busy(busy),
        .fifo_count(fifo_count), .err_range(err_range)
    );

    function automatic logic [7:0] m_clamp(input logic [7:0] a);
        return (a > 8'd180) ? 8'd180 : a;
    endfunction

    function automatic void m_reset();
        mq.delete();
        for (int i = 0; i < 4; i++) m_ang[i] = 8'd90;
        m_busy  = 1'b0;
        m_pulse = 1'b0;
        m_rem   = 0;
    endfunction

    // One frame boundary: finish dwell if due, then start the next pose if allowed.
    function automatic void m_tick(input bit en);
        logic [39:0] p;
        m_pulse = 1'b0;
        if (m_busy) begin
            m_rem--;
            if (m_rem == 0) m_busy = 1'b0;
        end
        if (!m_busy && en && mq.size() > 0) begin
            p = mq.pop_front();
            m_ang[0] = p[39:32];
            m_ang[1] = p[31:24];
            m_ang[2] = p[23:16];
            m_ang[3] = p[15:8];
            m_rem    = int'(p[7:0]);
            m_busy   = 1'b1;
            m_pulse  = 1'b1;
        end
    endfunction

    // Advance to the next negedge where frame_tick is high (bounded).
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < FC + 4);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout: no frame_tick within %0d cycles", n);
        end
    endtask

    // Present one command for one clock; called at a negedge, returns at the next.
    task automatic drive_push(input logic [7:0] a1, a2, a3, a4, h, output bit exp_err);
        cmd_angle1 = a1; cmd_angle2 = a2; cmd_angle3 = a3; cmd_angle4 = a4;
        cmd_hold   = h;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        exp_err    = (a1 > 8'd180) || (a2 > 8'd180) || (a3 > 8'd180) || (a4 > 8'd180);
        mq.push_back({m_clamp(a1), m_clamp(a2), m_clamp(a3), m_clamp(a4),
                      (h == 8'd0) ? 8'd1 : h});
    endtask

    task automatic test_reset();
        int n;
        int pulses = 0;
        rst_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({angle1, angle2, angle3, angle4, nextangle, frame_tick, busy, err_range, fifo_count}
            !== {8'd90, 8'd90, 8'd90, 8'd90, 4'b0000, 3'd0}) begin
            errors++;
            $display("FAIL reset_values: got %h %h %h %h na=%b ft=%b busy=%b err=%b cnt=%0d",
                     angle1, angle2, angle3, angle4, nextangle, frame_tick, busy, err_range, fifo_count);
        end
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (nextangle === 1'b1) pulses++;
        end while (frame_tick !== 1'b1 && n < FC + 4);
        checks++;
        if (n !== FC - 1) begin
            errors++;
            $display("FAIL first_tick: after %0d cycles, expected %0d", n, FC - 1);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: cmd_ready=%b expected 1", cmd_ready);
        end
        for (int f = 0; f < 2; f++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (nextangle === 1'b1) pulses++;
            end while (frame_tick !== 1'b1 && n < FC + 4);
            checks++;
            if (n !== FC) begin
                errors++;
                $display("FAIL tick_period: %0d cycles, expected %0d", n, FC);
            end
        end
        @(negedge clk);
        checks++;
        if (pulses !== 0 || {angle1, angle2, angle3, angle4} !== {4{8'd90}}) begin
            errors++;
            $display("FAIL idle_frames: nextangle pulses=%0d angles=%h%h%h%h expected 0, 5a5a5a5a",
                     pulses, angle1, angle2, angle3, angle4);
        end
    endtask

    task automatic test_basic();
        bit e;
        drive_push(8'd0, 8'd90, 8'd180, 8'd45, 8'd2, e);
        checks++;
        if (err_range !== e) begin
            errors++;
            $display("FAIL basic_err: err_range=%b expected %b", err_range, e);
        end
        for (int f = 0; f < 3; f++) begin
            wait_tick(); m_tick(enable); @(negedge clk);
            checks++;
            if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
                {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
                errors++;
                $display("FAIL basic_frame%0d: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                         f, angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                         m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
            end
            @(negedge clk);
            checks++;
            if (nextangle !== 1'b0) begin
                errors++;
                $display("FAIL basic_pulse_width%0d: nextangle=%b expected 0", f, nextangle);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit e;
        logic [7:0] a [4];
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) a[i] = 8'($urandom_range(0, 180));
            drive_push(a[0], a[1], a[2], a[3], 8'($urandom_range(0, 2)), e);
            checks++;
            if (cmd_ready !== (mq.size() < DEPTH) || err_range !== e) begin
                errors++;
                $display("FAIL b2b_push%0d: cmd_ready=%b err=%b expected %b %b",
                         k, cmd_ready, err_range, (mq.size() < DEPTH), e);
            end
        end
        // Fifth command waits on a full FIFO until the first pop frees a slot.
        cmd_angle1 = 8'd11; cmd_angle2 = 8'd22; cmd_angle3 = 8'd33; cmd_angle4 = 8'd44;
        cmd_hold   = 8'd1;
        cmd_valid  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL b2b_full: cmd_ready=%b cnt=%0d expected 0 4", cmd_ready, fifo_count);
        end
        wait_tick(); m_tick(enable); @(negedge clk);
        checks++;
        if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
            {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
            errors++;
            $display("FAIL b2b_first: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                     angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                     m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        mq.push_back({8'd11, 8'd22, 8'd33, 8'd44, 8'd1});
        checks++;
        if (fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL b2b_fifth: cnt=%0d expected 4", fifo_count);
        end
        for (int f = 0; f < 20 && (m_busy || mq.size() > 0); f++) begin
            wait_tick(); m_tick(enable); @(negedge clk);
            checks++;
            if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
                {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                         f, angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                         m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
            end
        end
    endtask

    task automatic test_range();
        bit e;
        drive_push(8'd200, 8'd10, 8'd255, 8'd181, 8'd0, e);
        checks++;
        if (err_range !== e) begin
            errors++;
            $display("FAIL range_err: err_range=%b expected %b", err_range, e);
        end
        @(negedge clk);
        checks++;
        if (err_range !== 1'b0) begin
            errors++;
            $display("FAIL range_err_width: err_range=%b expected 0", err_range);
        end
        drive_push(8'd180, 8'd0, 8'd1, 8'd179, 8'd1, e);
        checks++;
        if (err_range !== e) begin
            errors++;
            $display("FAIL range_edge: err_range=%b expected %b", err_range, e);
        end
        for (int f = 0; f < 6 && (m_busy || mq.size() > 0); f++) begin
            wait_tick(); m_tick(enable); @(negedge clk);
            checks++;
            if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
                {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
                errors++;
                $display("FAIL range_frame%0d: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                         f, angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                         m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
            end
        end
    endtask

    task automatic test_enable();
        bit e;
        enable = 1'b0;
        drive_push(8'd30, 8'd60, 8'd120, 8'd150, 8'd1, e);
        drive_push(8'd170, 8'd5, 8'd100, 8'd90, 8'd1, e);
        for (int f = 0; f < 5; f++) begin
            wait_tick(); m_tick(enable); @(negedge clk);
            checks++;
            if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
                {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
                errors++;
                $display("FAIL enable_frozen%0d: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                         f, angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                         m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
            end
        end
        enable = 1'b1;
        for (int f = 0; f < 6 && (m_busy || mq.size() > 0); f++) begin
            wait_tick(); m_tick(enable); @(negedge clk);
            checks++;
            if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
                {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
                errors++;
                $display("FAIL enable_run%0d: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                         f, angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                         m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
            end
        end
    endtask

    task automatic test_async_reset();
        bit e;
        drive_push(8'd12, 8'd34, 8'd56, 8'd78, 8'd3, e);
        drive_push(8'd99, 8'd88, 8'd77, 8'd66, 8'd1, e);
        for (int f = 0; f < 2; f++) begin
            wait_tick(); m_tick(enable); @(negedge clk);
            checks++;
            if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
                {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
                errors++;
                $display("FAIL arst_pre%0d: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                         f, angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                         m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
            {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
            errors++;
            $display("FAIL arst_async: got %h %h %h %h na=%b busy=%b cnt=%0d expected 5a5a5a5a na=0 busy=0 cnt=0",
                     angle1, angle2, angle3, angle4, nextangle, busy, fifo_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_tick(); m_tick(enable); @(negedge clk);
            checks++;
            if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
                {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
                errors++;
                $display("FAIL arst_post%0d: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                         f, angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                         m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
            end
        end
    endtask

    task automatic test_random();
        int left = 5;
        bit e;
        logic [7:0] a [4];
        for (int f = 0; f < 40 && (left > 0 || m_busy || mq.size() > 0); f++) begin
            if (left > 0 && mq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 400)) @(negedge clk);
                for (int i = 0; i < 4; i++) a[i] = 8'($urandom_range(0, 255));
                drive_push(a[0], a[1], a[2], a[3], 8'($urandom_range(0, 2)), e);
                left--;
                checks++;
                if (err_range !== e) begin
                    errors++;
                    $display("FAIL rand_err%0d: err_range=%b expected %b", f, err_range, e);
                end
            end
            enable = ($urandom_range(0, 3) != 0);
            wait_tick(); m_tick(enable); @(negedge clk);
            checks++;
            if ({angle1, angle2, angle3, angle4, nextangle, busy, fifo_count} !==
                {m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, 3'(mq.size())}) begin
                errors++;
                $display("FAIL rand_frame%0d: got %h %h %h %h na=%b busy=%b cnt=%0d expected %h %h %h %h na=%b busy=%b cnt=%0d",
                         f, angle1, angle2, angle3, angle4, nextangle, busy, fifo_count,
                         m_ang[0], m_ang[1], m_ang[2], m_ang[3], m_pulse, m_busy, mq.size());
            end
        end
        enable = 1'b1;
    endtask

`ifdef SERVO_SLEW_LIMIT_EN
    task automatic test_slew();
        bit e;
        int pulses = 0;
        drive_push(8'd100, 8'd90, 8'd90, 8'd90, 8'd1, e);
        for (int f = 0; f < 7; f++) begin
            wait_tick(); @(negedge clk);
            if (nextangle === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 5 || angle1 !== 8'd100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL slew: pulses=%0d angle1=%0d busy=%b expected 5 100 0", pulses, angle1, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SERVO_SLEW_LIMIT_EN
        test_slew();
`else
        test_basic();
        test_back_to_back();
        test_range();
        test_enable();
        test_async_reset();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
